// File: rtl/sha_sched_pkg.sv
// Shared types and helpers for the SHA-256 job scheduler.
// State encoding, default address width and watchdog counter sizing.
package sha_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_ACK       = 3'd4,
    S_FAULT     = 3'd5
  } sched_state_t;

  localparam int DEF_ADDR_W = 16;

  // Watchdog counter only has to reach TIMEOUT_CYCLES-2.
  function automatic int wd_width(input int timeout_cycles);
    return (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at i_rr_ptr and wraps,
// so the first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant_oh,
  output logic [IDX_W-1:0]   o_grant_idx,
  output logic               o_any_req
);

  logic [NUM_REQ-1:0] w_rot;
  logic [NUM_REQ-1:0] w_seen;
  logic [NUM_REQ-1:0] w_sel;
  logic [IDX_W-1:0]   w_idx_acc [NUM_REQ+1];

  // Rotate so the pointer sits at bit 0, pick the lowest set bit, rotate back.
  assign w_rot = NUM_REQ'({i_req, i_req} >> i_rr_ptr);

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pick
    if (gi == 0) begin : g_first
      assign w_seen[gi] = 1'b0;
    end else begin : g_rest
      assign w_seen[gi] = w_seen[gi-1] | w_rot[gi-1];
    end
    assign w_sel[gi] = w_rot[gi] & ~w_seen[gi];
  end

  assign o_grant_oh = NUM_REQ'(({w_sel, w_sel} << i_rr_ptr) >> NUM_REQ);

  assign w_idx_acc[0] = '0;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_enc
    assign w_idx_acc[gi+1] = w_idx_acc[gi] | (o_grant_oh[gi] ? IDX_W'(gi) : '0);
  end

  assign o_grant_idx = w_idx_acc[NUM_REQ];
  assign o_any_req   = |i_req;

endmodule

// File: rtl/sha256_job_scheduler.sv
// Shares one SHA-256 core among NUM_REQ requesters: round-robin grant,
// start pulse, done fall/rise tracking, per-job ack and a sticky watchdog fault.
module sha256_job_scheduler
  import sha_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_req_input_addr,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_req_hash_addr,
  output logic [NUM_REQ-1:0]          o_ack,
  output logic                        o_ack_err,
  output logic                        o_core_start,
  output logic [ADDR_W-1:0]           o_core_input_addr,
  output logic [ADDR_W-1:0]           o_core_hash_addr,
  input  logic                        i_core_done,
  output logic                        o_busy,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
  output logic                        o_fault,
  output logic [15:0]                 o_job_count
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = wd_width(TIMEOUT_CYCLES);

  sched_state_t       r_state, w_state_next;
  logic [IDX_W-1:0]   r_rr_ptr, r_grant_id, w_grant_idx;
  logic [NUM_REQ-1:0] r_grant_oh, w_grant_oh;
  logic               w_any_req, w_exit, w_timeout, r_err, r_fault;
  logic [WD_W-1:0]    r_wd_cnt;
  logic [ADDR_W-1:0]  r_core_input_addr, r_core_hash_addr;
  logic [15:0]        r_job_count;
  logic [ADDR_W-1:0]  w_in_acc [NUM_REQ+1];
  logic [ADDR_W-1:0]  w_hs_acc [NUM_REQ+1];

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req       (i_req),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx),
    .o_any_req   (w_any_req)
  );

  // One-hot AND-OR mux of the winner's address slices.
  assign w_in_acc[0] = '0;
  assign w_hs_acc[0] = '0;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_addr_mux
    assign w_in_acc[gi+1] = w_in_acc[gi] |
      ({ADDR_W{w_grant_oh[gi]}} & i_req_input_addr[gi*ADDR_W +: ADDR_W]);
    assign w_hs_acc[gi+1] = w_hs_acc[gi] |
      ({ADDR_W{w_grant_oh[gi]}} & i_req_hash_addr[gi*ADDR_W +: ADDR_W]);
  end

  // Expiry one count early so the error ack lands TIMEOUT_CYCLES after start.
  assign w_exit    = ((r_state == S_WAIT_BUSY) && !i_core_done) ||
                     ((r_state == S_WAIT_DONE) && i_core_done);
  assign w_timeout = !w_exit && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:      if (w_any_req && i_core_done) w_state_next = S_LAUNCH;
      S_LAUNCH:    w_state_next = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!i_core_done) w_state_next = S_WAIT_DONE;
                   else if (w_timeout) w_state_next = S_ACK;
      S_WAIT_DONE: if (i_core_done || w_timeout) w_state_next = S_ACK;
      S_ACK:       w_state_next = r_err ? S_FAULT : S_IDLE;
      S_FAULT:     w_state_next = S_FAULT;
      default:     w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_core_start = (r_state == S_LAUNCH);
    o_ack        = (r_state == S_ACK) ? r_grant_oh : '0;
    o_ack_err    = (r_state == S_ACK) && r_err;
    o_busy       = (r_state != S_IDLE) && (r_state != S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr          <= '0;
      r_grant_id        <= '0;
      r_grant_oh        <= '0;
      r_wd_cnt          <= '0;
      r_err             <= 1'b0;
      r_fault           <= 1'b0;
      r_job_count       <= '0;
      r_core_input_addr <= '0;
      r_core_hash_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any_req && i_core_done) begin
          r_grant_id        <= w_grant_idx;
          r_grant_oh        <= w_grant_oh;
          r_core_input_addr <= w_in_acc[NUM_REQ];
          r_core_hash_addr  <= w_hs_acc[NUM_REQ];
        end
        S_LAUNCH: begin
          r_wd_cnt <= '0;
          r_err    <= 1'b0;
        end
        S_WAIT_BUSY, S_WAIT_DONE: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (w_timeout) r_err <= 1'b1;
        end
        S_ACK: begin
          r_rr_ptr <= (r_grant_id == IDX_W'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
          if (r_err) r_fault     <= 1'b1;
          else       r_job_count <= r_job_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_grant_id        = r_grant_id;
  assign o_core_input_addr = r_core_input_addr;
  assign o_core_hash_addr  = r_core_hash_addr;
  assign o_fault           = r_fault;
  assign o_job_count       = r_job_count;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed bench for sha256_job_scheduler with a behavioural core and an
// expected-ack scoreboard; a second instance with a short watchdog covers timeout.
module tb_sha256_job_scheduler;

  localparam int N  = 4;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance (default watchdog) signals
  logic [N-1:0]    req;
  logic [AW-1:0]   in_addr [N];
  logic [AW-1:0]   hs_addr [N];
  logic [N*AW-1:0] req_in_flat, req_hs_flat;
  logic [N-1:0]    ack;
  logic            ack_err, core_start, core_done, busy, fault;
  logic [AW-1:0]   core_input_addr, core_hash_addr;
  logic [1:0]      grant_id;
  logic [15:0]     job_count;

  // Timeout instance signals
  logic [N-1:0]    to_req;
  logic [N-1:0]    to_ack;
  logic            to_ack_err, to_core_start, to_core_done, to_busy, to_fault;
  logic [AW-1:0]   to_core_input_addr, to_core_hash_addr;
  logic [1:0]      to_grant_id;
  logic [15:0]     to_job_count;

  for (genvar gi = 0; gi < N; gi++) begin : g_flat
    assign req_in_flat[gi*AW +: AW] = in_addr[gi];
    assign req_hs_flat[gi*AW +: AW] = hs_addr[gi];
  end

  sha256_job_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(4096)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_req             (req),
    .i_req_input_addr  (req_in_flat),
    .i_req_hash_addr   (req_hs_flat),
    .o_ack             (ack),
    .o_ack_err         (ack_err),
    .o_core_start      (core_start),
    .o_core_input_addr (core_input_addr),
    .o_core_hash_addr  (core_hash_addr),
    .i_core_done       (core_done),
    .o_busy            (busy),
    .o_grant_id        (grant_id),
    .o_fault           (fault),
    .o_job_count       (job_count)
  );

  sha256_job_scheduler #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(64)) dut_to (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_req             (to_req),
    .i_req_input_addr  (req_in_flat),
    .i_req_hash_addr   (req_hs_flat),
    .o_ack             (to_ack),
    .o_ack_err         (to_ack_err),
    .o_core_start      (to_core_start),
    .o_core_input_addr (to_core_input_addr),
    .o_core_hash_addr  (to_core_hash_addr),
    .i_core_done       (to_core_done),
    .o_busy            (to_busy),
    .o_grant_id        (to_grant_id),
    .o_fault           (to_fault),
    .o_job_count       (to_job_count)
  );

  // Behavioural core: done drops after start and returns after core_lat cycles.
  logic core_busy_r;
  int   core_cnt;
  int   core_lat;
  logic force_busy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy_r <= 1'b0;
      core_cnt    <= 0;
    end else if (core_start) begin
      core_busy_r <= 1'b1;
      core_cnt    <= core_lat;
    end else if (core_busy_r) begin
      if (core_cnt == 0) core_busy_r <= 1'b0;
      else               core_cnt    <= core_cnt - 1;
    end
  end
  assign core_done = !core_busy_r && !force_busy;

  typedef struct {
    int          idx;
    logic [15:0] ia;
    logic [15:0] ha;
    logic        err;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;
  int exp_jobs = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_job(input int idx);
    exp_t e;
    e.idx = idx;
    e.ia  = in_addr[idx];
    e.ha  = hs_addr[idx];
    e.err = 1'b0;
    sb.push_back(e);
  endtask

  // Waits for the next grant and ack of the main instance, checking against the scoreboard.
  task automatic run_job(input logic [N-1:0] req_after, output int start_lat);
    exp_t e;
    bit   seen;
    int   cyc;
    seen = 0;
    cyc  = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(negedge clk);
      cyc = k;
      if (core_start) seen = 1;
    end
    start_lat = cyc;
    chk("start_seen", 32'(seen), 1);
    e = sb[0];
    chk("core_in_addr", 32'(core_input_addr), 32'(e.ia));
    chk("core_hash_addr", 32'(core_hash_addr), 32'(e.ha));
    in_addr[e.idx] = ~e.ia;
    seen = 0;
    for (int k = 1; k <= 2000 && !seen; k++) begin
      @(negedge clk);
      if (ack != '0) seen = 1;
    end
    req = req_after;
    in_addr[e.idx] = e.ia;
    chk("ack_seen", 32'(seen), 1);
    e = sb.pop_front();
    chk("ack_vec", 32'(ack), 32'd1 << e.idx);
    chk("ack_err", 32'(ack_err), 32'(e.err));
    chk("grant_id", 32'(grant_id), 32'(e.idx));
    chk("core_in_hold", 32'(core_input_addr), 32'(e.ia));
    @(negedge clk);
    exp_jobs++;
    chk("ack_width", 32'(ack), 0);
    chk("job_count", 32'(job_count), 32'(exp_jobs));
  endtask

  initial begin
    int  lat, starts, cyc;
    bit  seen;
    req = '0; to_req = '0; to_core_done = 1'b1; force_busy = 1'b0; core_lat = 300;
    for (int i = 0; i < N; i++) begin
      in_addr[i] = 16'h1000 + 16'(i * 16'h0111);
      hs_addr[i] = 16'h2000 + 16'(i * 16'h0222);
    end
    in_addr[2] = 16'h0010;
    hs_addr[2] = 16'h0100;

    // Reset state
    #2;
    chk("rst_core_start", 32'(core_start), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_job_count", 32'(job_count), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_core_in", 32'(core_input_addr), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single job to requester 2
    @(negedge clk);
    push_job(2);
    req = 4'b0100;
    run_job(4'b0000, lat);
    chk("single_start_lat", 32'(lat), 1);

    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    exp_jobs = 0;

    // Fairness: all four requesting continuously
    core_lat = 20;
    @(negedge clk);
    push_job(0); push_job(1); push_job(2); push_job(3); push_job(0);
    req = 4'b1111;
    run_job(4'b1111, lat);
    run_job(4'b1111, lat);
    run_job(4'b1111, lat);
    run_job(4'b1111, lat);
    run_job(4'b0000, lat);

    // Pointer resume: grant 1, then {0,1} requesting must go 0 then 1
    @(negedge clk);
    push_job(1);
    req = 4'b0010;
    run_job(4'b0000, lat);
    @(negedge clk);
    push_job(0); push_job(1);
    req = 4'b0011;
    run_job(4'b0010, lat);
    run_job(4'b0000, lat);

    // Core still busy while idle blocks the grant
    @(negedge clk);
    force_busy = 1'b1;
    push_job(0);
    req = 4'b0001;
    starts = 0;
    repeat (20) begin
      @(negedge clk);
      if (core_start) starts++;
    end
    chk("busy_block", 32'(starts), 0);
    force_busy = 1'b0;
    run_job(4'b0000, lat);
    chk("busy_release_lat", 32'(lat), 1);

    // Watchdog timeout on the short-timeout instance
    @(negedge clk);
    to_req = 4'b0001;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (to_core_start) seen = 1;
    end
    chk("to_start_seen", 32'(seen), 1);
    to_core_done = 1'b0;
    seen = 0;
    cyc = 0;
    for (int k = 1; k <= 200 && !seen; k++) begin
      @(negedge clk);
      cyc = k;
      if (to_ack != '0) seen = 1;
    end
    chk("to_ack_seen", 32'(seen), 1);
    chk("to_ack_delay", 32'(cyc), 64);
    chk("to_ack_vec", 32'(to_ack), 1);
    chk("to_ack_err", 32'(to_ack_err), 1);
    @(negedge clk);
    chk("to_fault", 32'(to_fault), 1);
    chk("to_busy", 32'(to_busy), 0);
    chk("to_job_count", 32'(to_job_count), 0);
    to_core_done = 1'b1;
    to_req = 4'b1111;
    starts = 0;
    repeat (200) begin
      @(negedge clk);
      if (to_core_start) starts++;
    end
    chk("to_no_start", 32'(starts), 0);
    chk("to_fault_sticky", 32'(to_fault), 1);
    to_req = '0;

    // Reset in the middle of a job
    @(negedge clk);
    req = 4'b0100;
    seen = 0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(negedge clk);
      if (core_start) seen = 1;
    end
    chk("mid_start_seen", 32'(seen), 1);
    repeat (10) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    rst_n = 1'b0;
    req = '0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_start", 32'(core_start), 0);
    chk("mid_rst_grant", 32'(grant_id), 0);
    chk("mid_rst_core_in", 32'(core_input_addr), 0);
    chk("mid_rst_core_hash", 32'(core_hash_addr), 0);
    chk("mid_rst_job_count", 32'(job_count), 0);
    chk("mid_rst_to_fault", 32'(to_fault), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_jobs = 0;
    @(negedge clk);
    push_job(0);
    req = 4'b0011;
    run_job(4'b0000, lat);
    chk("post_rst_lat", 32'(lat), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_job_scheduler.md
Name: sha256_job_scheduler

Overview:
Round-robin scheduler that shares one simplified SHA-256 core among NUM_REQ requesters (e.g. nonce workers of the miner).
- Requester handshake: each requester posts a job as a pair (input_addr, hash_addr).
- Dispatch: the scheduler grants one job at a time, registers its addresses, pulses core start, waits for the core's done to fall and then rise again, and acks the requester.
- Protection: a watchdog detects a hung core and latches a fault.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 16, memory address width (matches core).
- TIMEOUT_CYCLES, 4096, maximum cycles from core_start to core_done rising before fault.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester job request (level).
- req_input_addr  in  NUM_REQ*ADDR_W  flattened; slice i = input_addr of requester i.
- req_hash_addr  in  NUM_REQ*ADDR_W  flattened; slice i = hash_addr of requester i.
- ack  out  NUM_REQ  one-cycle pulse, job i complete.
- ack_err  out  1  qualifies ack: 1 = job aborted by timeout.
- core_start  out  1  one-cycle start pulse to core.
- core_input_addr  out  ADDR_W  to core input_addr.
- core_hash_addr  out  ADDR_W  to core hash_addr.
- core_done  in  1  core done (high whenever core is idle).
- busy  out  1  job in flight (state != IDLE and != FAULT).
- grant_id  out  $clog2(NUM_REQ)  index of current/last granted requester.
- fault  out  1  sticky timeout flag.
- job_count  out  16  completed successful jobs, wraps at 0xFFFF->0.

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; state IDLE.
- Reset mid-job returns to IDLE immediately. The core is reset from the same rst_n.
- States: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, ACK, FAULT.
- IDLE:
  - Stays while req==0 or core_done==0.
  - When any req is high and core_done==1: round-robin pick, starting search at rr_ptr, lowest index after rr_ptr wins.
  - Register grant_id, core_input_addr, core_hash_addr from the winner's slices, then go to LAUNCH.
- LAUNCH: core_start=1 for exactly this cycle; clear the watchdog counter; go to WAIT_BUSY.
- WAIT_BUSY: wait for core_done==0, then go to WAIT_DONE.
- WAIT_DONE: wait for core_done==1, then go to ACK.
- Watchdog:
  - Counter increments every cycle in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES-1 without the exit condition, go to ACK with the error flag set.
- ACK:
  - ack[grant_id]=1 for one cycle; ack_err = error flag.
  - rr_ptr = grant_id+1, modulo NUM_REQ.
  - If no error: job_count+1, then IDLE.
  - If error: fault=1, then FAULT.
- FAULT: absorbing state, left only via rst_n. No further grants, no core_start. busy=0.
- Timing:
  - req seen in IDLE at cycle t gives core_start at t+1.
  - ack is asserted the cycle after core_done is sampled rising.
  - Minimum IDLE->IDLE overhead is 4 cycles plus core time.
- Requester rules:
  - Hold req and addresses stable until ack.
  - Addresses are sampled only at grant; later changes are ignored.
  - req still high in the cycle after ack counts as a new job, arbitrated fairly against the others.
- Simultaneous requests: served in round-robin order. Each requester is served at most once per NUM_REQ grants while all are requesting.
- Withdrawn req after grant: the job still runs and acks.
- Core-done rule: core_done low while in IDLE (core still busy) blocks the grant.
- Addresses held on core ports until the next grant. core_start never asserts twice per job.

Decomposition:
- sha_sched_pkg:
  - sched_state_t enum (3-bit).
  - ADDR_W default.
  - TIMEOUT width function ($clog2).
- Sub-module rr_arbiter:
  - Inputs: req vector, rr_ptr.
  - Outputs: grant one-hot, grant index, any_req.
  - Purely combinational, parameterised by NUM_REQ.

Test Plan:
- Single job:
  - Stimulus: req=4'b0100, input_addr[2]=0x0010, hash_addr[2]=0x0100; core model holds done low for 300 cycles.
  - Response: core_start one cycle after req; core addrs 0x0010/0x0100; ack=4'b0100 with ack_err=0; job_count=1; grant_id=2.
- Fairness:
  - Stimulus: req=4'b1111 held continuously.
  - Response: grant order 0,1,2,3,0; each ack exactly one cycle; job_count=5 after 5 jobs.
- Pointer resume:
  - Stimulus: after a grant to 1, req=4'b0011.
  - Response: next grant=0 (search starts at 2, wraps), then 1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=64; core model never raises done.
  - Response: ack with ack_err=1 exactly 64 cycles after core_start; fault=1; further req gives no core_start for 200 cycles.
- Core busy at idle:
  - Stimulus: core_done=0 while req=4'b0001.
  - Response: no core_start until core_done=1.
- Reset mid-job:
  - Stimulus: rst_n low during WAIT_DONE.
  - Response: all outputs 0, fault cleared, job_count=0; next req handled normally starting from requester 0.
